// File: rtl/fsm_input_pkg.sv
`default_nettype none
// ============================================================================
// fsm_input_pkg : shared types and constants for the fsm_input_sequencer block
// Revision      : 1.0
// ============================================================================
package fsm_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  localparam int N_REQ = 3;
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_C = 2;

  typedef logic [3:0] cnt_t;
  typedef logic [1:0] ptr_t;

  function automatic ptr_t rr_next(input ptr_t p);
    return (p == ptr_t'(REQ_C)) ? ptr_t'(REQ_A) : p + ptr_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_input_sequencer_if.sv
`default_nettype none
// ============================================================================
// fsm_input_sequencer_if : raw request inputs and conditioned strobe outputs
// Revision               : 1.0
// ============================================================================
interface fsm_input_sequencer_if;

  logic a_in;
  logic b_in;
  logic c_in;
  logic a_out;
  logic b_out;
  logic c_out;
  logic busy;
  logic overrun;

  modport master (
    output a_in, b_in, c_in,
    input  a_out, b_out, c_out, busy, overrun
  );

  modport slave (
    input  a_in, b_in, c_in,
    output a_out, b_out, c_out, busy, overrun
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
// rr_arbiter3 : combinational 3-way round-robin, search starts at ptr
// Revision    : 1.0
// ============================================================================
module rr_arbiter3
  import fsm_input_pkg::*;
(
  input  wire logic [N_REQ-1:0] req,
  input  wire ptr_t             ptr,
  output logic [N_REQ-1:0]      grant,
  output ptr_t                  next_ptr
);

  ptr_t w_idx;
  logic w_found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    w_idx    = ptr;
    w_found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        next_ptr     = rr_next(w_idx);
        w_found      = 1'b1;
      end
      w_idx = rr_next(w_idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsm_input_sequencer.sv
`default_nettype none
// ============================================================================
// fsm_input_sequencer : turns A/B/C rising edges into serialised one-hot strobes
// Optional macro      : FSM_INPUT_SYNC_EN (two-flop input synchronisers)
// Revision            : 1.0
// ============================================================================
module fsm_input_sequencer
  import fsm_input_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
)(
  input  wire logic             clk,
  input  wire logic             rst_n,
  fsm_input_sequencer_if.slave  bus
);

  localparam cnt_t c_hold_load = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t c_gap_load  = (GAP_CYCLES == 0) ? cnt_t'(0) : cnt_t'(GAP_CYCLES - 1);

  seq_state_t       r_state, w_state_nxt;
  cnt_t             r_cnt, w_cnt_nxt;
  ptr_t             r_ptr, w_ptr_nxt, w_ptr_arb;
  logic [N_REQ-1:0] r_out, w_out_nxt;
  logic [N_REQ-1:0] r_prev, r_pend;
  logic             r_overrun;
  logic [N_REQ-1:0] w_raw, w_req, w_rise, w_grant_arb, w_grant, w_pend_nxt, w_drop;

  assign w_raw = {bus.c_in, bus.b_in, bus.a_in};

`ifdef FSM_INPUT_SYNC_EN
  logic [N_REQ-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_req = r_sync2;
`else
  assign w_req = w_raw;
`endif

  assign w_rise = w_req & ~r_prev;

  rr_arbiter3 u_arb (
    .req      (r_pend),
    .ptr      (r_ptr),
    .grant    (w_grant_arb),
    .next_ptr (w_ptr_arb)
  );

  // Pending bits are only consumed when the FSM actually issues a grant.
  assign w_grant    = (r_state == IDLE) ? w_grant_arb : '0;
  assign w_pend_nxt = (r_pend & ~w_grant) | w_rise;
  assign w_drop     = w_rise & r_pend & ~w_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = '0;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (|r_pend) begin
          w_out_nxt   = w_grant;
          w_cnt_nxt   = c_hold_load;
          w_ptr_nxt   = w_ptr_arb;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = GAP;
            w_cnt_nxt   = c_gap_load;
          end
        end else begin
          w_out_nxt = r_out;
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= ptr_t'(REQ_A);
      r_out     <= '0;
      r_prev    <= '1;
      r_pend    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_out     <= w_out_nxt;
      r_prev    <= w_req;
      r_pend    <= w_pend_nxt;
      r_overrun <= |w_drop;
    end
  end

  assign bus.a_out   = r_out[REQ_A];
  assign bus.b_out   = r_out[REQ_B];
  assign bus.c_out   = r_out[REQ_C];
  assign bus.busy    = (r_state != IDLE);
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire
